// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Request/response bundle between the pipeline and the
//               multiply/accumulate sequencer.
//               start/mode/a/b/abort : request side (pipeline -> sequencer)
//               busy/done/hi/lo      : status and HI/LO results
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mode, a, b, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mode, a, b, abort,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : 32x32 -> 64 multiply / multiply-accumulate unit owning the
//               architectural HI/LO registers. Default build uses a radix-2
//               shift-add datapath (32 CALC cycles); defining MULDIV_FAST_EN
//               replaces CALC with one combinational 32x32 multiply.
//               Modes: 0 mul, 1 madd (signed), 2 maddu, 3 mulu (unsigned).
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - muldiv_sequencer_if.slave (start, mode, a, b, abort
//                      in; busy, done, hi, lo out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer (
    input  wire logic          clk,
    input  wire logic          rst,
    muldiv_sequencer_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CALC   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    logic [1:0]  r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [1:0]  r_mode;
    logic        r_sign;
    logic [63:0] r_mcand;    // |a|, shifted left once per CALC cycle
    logic [31:0] r_mplier;   // |b|, shifted right once per CALC cycle
`ifndef MULDIV_FAST_EN
    logic [63:0] r_prod;
    logic [4:0]  r_count;
`endif

    // Operand conditioning at the accepting edge. Two's complement negation
    // of 32'h80000000 yields 32'h80000000, which is the correct magnitude
    // once the value is treated as unsigned.
    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_sign;

    assign w_signed = ~bus.mode[1];
    assign w_a_mag  = (w_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag  = (w_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    assign w_sign   = w_signed & (bus.a[31] ^ bus.b[31]);

    // Result formation in FINISH
    logic [63:0] w_mag_prod;
    logic [63:0] w_prod;
    logic        w_accum;
    logic [63:0] w_result;

`ifdef MULDIV_FAST_EN
    assign w_mag_prod = r_mcand * {32'd0, r_mplier};
`else
    assign w_mag_prod = r_prod;
`endif
    assign w_prod   = r_sign ? (~w_mag_prod + 64'd1) : w_mag_prod;
    assign w_accum  = r_mode[0] ^ r_mode[1];
    assign w_result = w_accum ? ({r_hi, r_lo} + w_prod) : w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_mode   <= 2'd0;
            r_sign   <= 1'b0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
`ifndef MULDIV_FAST_EN
            r_prod   <= 64'd0;
            r_count  <= 5'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // abort beats start when both arrive while idle
                    if (bus.start && !bus.abort) begin
                        r_mode   <= bus.mode;
                        r_sign   <= w_sign;
                        r_mcand  <= {32'd0, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_busy   <= 1'b1;
`ifdef MULDIV_FAST_EN
                        r_state  <= c_FINISH;
`else
                        r_prod   <= 64'd0;
                        r_count  <= 5'd0;
                        r_state  <= c_CALC;
`endif
                    end
                end
`ifndef MULDIV_FAST_EN
                c_CALC: begin
                    if (bus.abort) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_mplier[0]) begin
                            r_prod <= r_prod + r_mcand;
                        end
                        r_mcand  <= {r_mcand[62:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                        r_count  <= r_count + 5'd1;   // wraps 31 -> 0
                        if (r_count == 5'd31) begin
                            r_state <= c_FINISH;
                        end
                    end
                end
`endif
                c_FINISH: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.abort) begin
                        r_hi   <= w_result[63:32];
                        r_lo   <= w_result[31:0];
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. Directed vectors
//               with fixed expected HI/LO, abort/reset sequences, then random
//               operations compared against an arithmetic reference model.
//               Timing expectations follow MULDIV_FAST_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_EN
    localparam int c_LAT      = 2;   // cycle in which done is high
    localparam int c_IGN_AT   = 1;
    localparam int c_ABORT_AT = 1;
    localparam int c_RST_AT   = 1;
`else
    localparam int c_LAT      = 34;
    localparam int c_IGN_AT   = 5;
    localparam int c_ABORT_AT = 10;
    localparam int c_RST_AT   = 20;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus_if ();

    muldiv_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] model = 64'd0;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_hl;
        int          ign;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign- or zero-extended operands
    function automatic logic [63:0] ref_op(input logic [63:0] acc, input logic [1:0] m,
                                           input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (m)
            2'd0:    return sp;
            2'd1:    return acc + sp;
            2'd2:    return acc + up;
            default: return up;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Entered at the negedge of cycle 0; returns at the negedge of cycle c_LAT
    // with start low, so another op may be issued immediately.
    task automatic do_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input int abort_at, input int rst_at, input int ign_at);
        int          stop;
        logic        exp_busy;
        logic        exp_done;
        logic [63:0] exp_hl;
        stop = 0;
        if (rst_at > 0)        exp_hl = 64'd0;
        else if (abort_at > 0) exp_hl = model;
        else                   exp_hl = ref_op(model, m, a, b);
        bus_if.start = 1'b1;
        bus_if.mode  = m;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.abort = 1'b0;
        for (int cyc = 1; cyc <= c_LAT; cyc++) begin
            @(negedge clk);
            exp_busy = (stop == 0) ? (cyc < c_LAT) : (cyc <= stop);
            exp_done = (stop == 0) && (cyc == c_LAT);
            check($sformatf("busy_c%0d", cyc), {63'd0, bus_if.busy}, {63'd0, exp_busy});
            check($sformatf("done_c%0d", cyc), {63'd0, bus_if.done}, {63'd0, exp_done});
            bus_if.start = (cyc == ign_at);
            bus_if.mode  = 2'($urandom_range(0, 3));
            bus_if.a     = $urandom;
            bus_if.b     = $urandom;
            bus_if.abort = (cyc == abort_at);
            rst          = (cyc == rst_at);
            if (cyc == abort_at || cyc == rst_at) stop = cyc;
        end
        check("hilo", {bus_if.hi, bus_if.lo}, exp_hl);
        model = exp_hl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", {63'd0, bus_if.busy}, 64'd0);
            check("idle_done", {63'd0, bus_if.done}, 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 0};
        vecs[1] = '{2'd0, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 0};
        vecs[2] = '{2'd1, 32'h00000002, 32'h00000003, 64'h00000001_00000006, 0};
        vecs[3] = '{2'd0, 32'h00000000, 32'h00000000, 64'h00000000_00000000, 0};
        vecs[4] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0};
        vecs[5] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 0};
        vecs[6] = '{2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, c_IGN_AT};
        vecs[7] = '{2'd3, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, 0};
        vecs[8] = '{2'd1, 32'h80000000, 32'h00000001, 64'h00000001_7FFFFFFE, 0};

        bus_if.start = 1'b0;
        bus_if.mode  = 2'd0;
        bus_if.a     = 32'd0;
        bus_if.b     = 32'd0;
        bus_if.abort = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        check("rst_done", {63'd0, bus_if.done}, 64'd0);
        check("rst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        rst = 1'b0;

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].mode, vecs[i].a, vecs[i].b, 0, 0, vecs[i].ign);
            check($sformatf("vec%0d_hilo", i), {bus_if.hi, bus_if.lo}, vecs[i].exp_hl);
        end
        idle(2);

        // Abort mid-operation: HI/LO hold, no done
        do_op(2'd0, 32'd5, 32'd6, c_ABORT_AT, 0, 0);
        check("abort_hilo", {bus_if.hi, bus_if.lo}, 64'h00000001_7FFFFFFE);
        idle(1);

        // start and abort together while idle: not accepted
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        bus_if.mode  = 2'd3;
        bus_if.a     = 32'd9;
        bus_if.b     = 32'd9;
        @(negedge clk);
        check("abort_start_busy", {63'd0, bus_if.busy}, 64'd0);
        bus_if.start = 1'b0;
        bus_if.abort = 1'b1;      // abort alone while idle
        idle(1);
        bus_if.abort = 1'b0;
        idle(1);
        check("abort_start_hilo", {bus_if.hi, bus_if.lo}, model);

        // Reset mid-operation clears HI/LO, no done
        do_op(2'd1, 32'd1234, 32'd5678, 0, c_RST_AT, 0);
        idle(1);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            int ab;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, c_LAT - 1)) : 0;
            do_op(2'($urandom_range(0, 3)), pick(), pick(), ab, 0, 0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
